// File: rtl/robot_motion_exec.sv
`default_nettype none
// ============================================================================
// Module   : robot_motion_exec
// Purpose  : Executes front/rotate command levels as timed, quantised
//            step/dir wheel motions; tracks heading and an (x,y) odometer.
//            Odometer registers are built only when MOTION_ODOM_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module robot_motion_exec #(
    parameter int STEPS_PER_CELL = 200,
    parameter int STEPS_PER_TURN = 100,
    parameter int STEP_DIV       = 50,
    parameter int POS_W          = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             front,
    input  logic             rotate,
    output logic             step_l,
    output logic             step_r,
    output logic             dir_l,
    output logic             dir_r,
    output logic             busy,
    output logic             done,
    output logic [1:0]       heading,
    output logic [POS_W-1:0] pos_x,
    output logic [POS_W-1:0] pos_y
);

    localparam int N_MAX = (STEPS_PER_CELL > STEPS_PER_TURN) ? STEPS_PER_CELL : STEPS_PER_TURN;
    localparam int SC_W  = $clog2(N_MAX + 1);
    localparam int DIV_W = $clog2(STEP_DIV);

    localparam logic [SC_W-1:0]  CELL_N   = SC_W'(STEPS_PER_CELL);
    localparam logic [SC_W-1:0]  TURN_N   = SC_W'(STEPS_PER_TURN);
    localparam logic [SC_W-1:0]  SC_ONE   = SC_W'(1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MOVE = 2'd1,
        TURN = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [DIV_W-1:0] div_cnt, div_n;
    logic [SC_W-1:0]  step_cnt, sc_n;
    logic [SC_W-1:0]  limit;
    logic             step_q, step_n;
    logic             dir_l_n, dir_r_n, busy_n, done_n;
    logic [1:0]       head_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            div_cnt  <= '0;
            step_cnt <= '0;
            step_q   <= 1'b0;
            dir_l    <= 1'b1;
            dir_r    <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            heading  <= 2'd0;
        end else begin
            state    <= state_n;
            div_cnt  <= div_n;
            step_cnt <= sc_n;
            step_q   <= step_n;
            dir_l    <= dir_l_n;
            dir_r    <= dir_r_n;
            busy     <= busy_n;
            done     <= done_n;
            heading  <= head_n;
        end
    end

    // The first pulse is launched on the entry edge; step_cnt counts pulses issued.
    always_comb begin
        state_n = state;
        div_n   = div_cnt;
        sc_n    = step_cnt;
        step_n  = 1'b0;
        dir_l_n = dir_l;
        dir_r_n = dir_r;
        busy_n  = busy;
        done_n  = 1'b0;
        head_n  = heading;
        limit   = (state == TURN) ? TURN_N : CELL_N;
        case (state)
            IDLE: begin
                if (rotate || front) begin
                    state_n = rotate ? TURN : MOVE;
                    div_n   = '0;
                    sc_n    = SC_ONE;
                    step_n  = 1'b1;
                    dir_l_n = 1'b1;
                    dir_r_n = ~rotate;
                    busy_n  = 1'b1;
                end
            end
            MOVE, TURN: begin
                if (div_cnt == DIV_LAST) begin
                    div_n = '0;
                    if (step_cnt == limit) begin
                        state_n = IDLE;
                        sc_n    = '0;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        if (state == TURN) begin
                            head_n = heading + 2'd1;
                        end
                    end else begin
                        sc_n   = step_cnt + SC_ONE;
                        step_n = 1'b1;
                    end
                end else begin
                    div_n = div_cnt + DIV_ONE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign step_l = step_q;
    assign step_r = step_q;

`ifdef MOTION_ODOM_EN
    localparam logic signed [POS_W-1:0] POS_ONE = POS_W'(1);

    logic signed [POS_W-1:0] px, py;
    logic                    move_done;

    // Heading is frozen for the whole move, so it selects the axis at completion.
    assign move_done = (state == MOVE) && (div_cnt == DIV_LAST) && (step_cnt == CELL_N);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            px <= '0;
            py <= '0;
        end else if (move_done) begin
            case (heading)
                2'd0: py <= py + POS_ONE;
                2'd1: px <= px + POS_ONE;
                2'd2: py <= py - POS_ONE;
                2'd3: px <= px - POS_ONE;
                default: ;
            endcase
        end
    end

    assign pos_x = px;
    assign pos_y = py;
`else
    assign pos_x = '0;
    assign pos_y = '0;
`endif

endmodule
`default_nettype wire
